// File: rtl/lap_timer_core_if.sv
// lap_timer_core_if: control pulses in, running time and lap FIFO status out.
// Latency: none, plain wires between the control unit and the timer core.
// Backpressure: none; laps are drained with a one-cycle pop pulse gated by o_lap_valid.
interface lap_timer_core_if #(
   parameter int LAP_DEPTH = 4
) ();
   logic                       i_run_stop;
   logic                       i_clear;
   logic                       i_mode;
   logic                       i_lap;
   logic                       i_lap_pop;
   logic [31:0]                o_time;
   logic [31:0]                o_lap_data;
   logic                       o_lap_valid;
   logic [$clog2(LAP_DEPTH):0] o_lap_count;
   logic                       o_lap_ovf;
   logic                       o_running;
   logic                       o_alarm;

   modport master (
      output i_run_stop, i_clear, i_mode, i_lap, i_lap_pop,
      input  o_time, o_lap_data, o_lap_valid, o_lap_count, o_lap_ovf, o_running, o_alarm
   );

   modport slave (
      input  i_run_stop, i_clear, i_mode, i_lap, i_lap_pop,
      output o_time, o_lap_data, o_lap_valid, o_lap_count, o_lap_ovf, o_running, o_alarm
   );
endinterface

// File: rtl/lap_timer_core.sv
// lap_timer_core: run/stop/clear hour:min:sec:csec counter with prescaler, up/down mode, lap FIFO.
// Latency: o_time updates the cycle after each internal tick; a lap reaches the FIFO head one cycle after i_lap.
// Backpressure: none on the counter; laps arriving while the FIFO is full are dropped and flagged in o_lap_ovf.
// Optional macro COUNTDOWN_STOP_EN: down mode stops at zero (DONE state, one-cycle o_alarm) instead of wrapping.
module lap_timer_core #(
   parameter int CLK_HZ    = 100_000_000,
   parameter int TICK_HZ   = 100,
   parameter int HOUR_MAX  = 24,
   parameter int LAP_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   lap_timer_core_if.slave  bus
);
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRESC_TC = PW'(DIV - 1);
   localparam logic [6:0] HOUR_LAST = 7'(HOUR_MAX - 1);
   localparam int AW = $clog2(LAP_DEPTH);
   localparam logic [AW:0] LAP_FULL = (AW+1)'(LAP_DEPTH);

`ifdef COUNTDOWN_STOP_EN
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2, DONE = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;
`endif

   state_t state, state_nx;
   logic   clear_ok, hit_zero, tick;

   logic [PW-1:0] presc;
   logic [6:0] hour, csec, nx_hour, nx_csec;
   logic [5:0] min, sec, nx_min, nx_sec;
   logic [31:0] time_q;

   logic [31:0]   lap_mem [LAP_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   lap_cnt;
   logic          lap_ovf, lap_req, lap_full, push_do, pop_do;

   assign time_q = {1'b0, hour, 2'b00, min, 2'b00, sec, 1'b0, csec};
   assign tick   = (state == RUN) && (presc == PRESC_TC);

   // Next value of the chained time fields for one tick in the current count direction.
   always_comb begin
      nx_hour = hour;
      nx_min  = min;
      nx_sec  = sec;
      nx_csec = csec;
      if (!bus.i_mode) begin
         if (csec != 7'd99) nx_csec = csec + 7'd1;
         else begin
            nx_csec = 7'd0;
            if (sec != 6'd59) nx_sec = sec + 6'd1;
            else begin
               nx_sec = 6'd0;
               if (min != 6'd59) nx_min = min + 6'd1;
               else begin
                  nx_min  = 6'd0;
                  nx_hour = (hour == HOUR_LAST) ? 7'd0 : hour + 7'd1;
               end
            end
         end
      end else begin
         if (csec != 7'd0) nx_csec = csec - 7'd1;
         else begin
            nx_csec = 7'd99;
            if (sec != 6'd0) nx_sec = sec - 6'd1;
            else begin
               nx_sec = 6'd59;
               if (min != 6'd0) nx_min = min - 6'd1;
               else begin
                  nx_min  = 6'd59;
                  nx_hour = (hour == 7'd0) ? HOUR_LAST : hour - 7'd1;
               end
            end
         end
      end
   end

   // Control FSM next state; an honoured clear outranks a coincident run/stop pulse.
   always_comb begin
      state_nx = state;
      clear_ok = 1'b0;
      hit_zero = 1'b0;
      case (state)
         IDLE: begin
            if (bus.i_clear) clear_ok = 1'b1;
            else if (bus.i_run_stop) state_nx = RUN;
         end
         RUN: begin
`ifdef COUNTDOWN_STOP_EN
            // A down tick landing on (or sitting at) zero ends the countdown.
            if (tick && bus.i_mode &&
                ((time_q == 32'd0) || ({nx_hour, nx_min, nx_sec, nx_csec} == 26'd0))) begin
               hit_zero = 1'b1;
               state_nx = DONE;
            end else
`endif
            if (bus.i_run_stop) state_nx = STOP;
         end
         STOP: begin
            if (bus.i_clear) clear_ok = 1'b1;
            else if (bus.i_run_stop) state_nx = RUN;
         end
`ifdef COUNTDOWN_STOP_EN
         DONE: begin
            if (bus.i_clear) clear_ok = 1'b1;
         end
`endif
         default: state_nx = IDLE;
      endcase
      if (clear_ok) state_nx = IDLE;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Prescaler advances only while running so a stop/resume keeps the tick phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                presc <= '0;
      else if (clear_ok)      presc <= '0;
      else if (state == RUN)  presc <= tick ? '0 : presc + 1'b1;
   end

   // Time fields load on each tick, reset to zero on clear or on countdown end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {hour, min, sec, csec} <= '0;
      end else if (clear_ok || hit_zero) begin
         {hour, min, sec, csec} <= '0;
      end else if (tick) begin
         {hour, min, sec, csec} <= {nx_hour, nx_min, nx_sec, nx_csec};
      end
   end

`ifdef COUNTDOWN_STOP_EN
   logic alarm_q;
   // One-cycle alarm pulse aligned with the zero value appearing on o_time.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) alarm_q <= 1'b0;
      else     alarm_q <= hit_zero;
   end
   assign bus.o_alarm = alarm_q;
`else
   assign bus.o_alarm = 1'b0;
`endif

   // Lap FIFO: a pop in the same cycle frees the slot, so lap+pop while full is not an overflow.
   assign lap_req  = bus.i_lap && (state == RUN);
   assign lap_full = (lap_cnt == LAP_FULL);
   assign pop_do   = bus.i_lap_pop && (lap_cnt != '0);
   assign push_do  = lap_req && (!lap_full || pop_do);

   // Lap storage needs no reset; the head is masked to zero when empty.
   always_ff @(posedge clk) begin
      if (push_do) lap_mem[wr_ptr] <= time_q;
   end

   // FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         lap_cnt <= '0;
         lap_ovf <= 1'b0;
      end else if (clear_ok) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         lap_cnt <= '0;
         lap_ovf <= 1'b0;
      end else begin
         if (push_do) wr_ptr <= wr_ptr + 1'b1;
         if (pop_do)  rd_ptr <= rd_ptr + 1'b1;
         if (push_do && !pop_do)      lap_cnt <= lap_cnt + 1'b1;
         else if (pop_do && !push_do) lap_cnt <= lap_cnt - 1'b1;
         if (lap_req && lap_full && !pop_do) lap_ovf <= 1'b1;
      end
   end

   assign bus.o_time      = time_q;
   assign bus.o_lap_data  = (lap_cnt != '0) ? lap_mem[rd_ptr] : 32'd0;
   assign bus.o_lap_valid = (lap_cnt != '0);
   assign bus.o_lap_count = lap_cnt;
   assign bus.o_lap_ovf   = lap_ovf;
   assign bus.o_running   = (state == RUN);
endmodule

// File: tb/tb_lap_timer_core.sv
// tb_lap_timer_core: directed stimulus for lap_timer_core, checked against a centisecond-count model every cycle.
// Latency: model updates on the rising edge, DUT outputs compared on the falling edge.
// Backpressure: none; all waits are fixed cycle counts so the run always terminates.
module tb_lap_timer_core;
   localparam int CLK_HZ = 1000, TICK_HZ = 100, HOUR_MAX = 24, LAP_DEPTH = 4;
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int MOD = HOUR_MAX * 360000;
   localparam int S_IDLE = 0, S_RUN = 1, S_STOP = 2, S_DONE = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   lap_timer_core_if #(.LAP_DEPTH(LAP_DEPTH)) bus ();

   lap_timer_core #(
      .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .HOUR_MAX(HOUR_MAX), .LAP_DEPTH(LAP_DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pack(input int t);
      int h, m, s, c;
      h = t / 360000;
      m = (t / 6000) % 60;
      s = (t / 100) % 60;
      c = t % 100;
      return {8'(h), 8'(m), 8'(s), 8'(c)};
   endfunction

   // Model: time as a total centisecond count, state as a small integer, laps as a queue.
   int          m_st, m_t, m_ph;
   bit          m_ovf, m_alarm;
   logic [31:0] m_q[$];
   bit          m_tick, m_lap, m_clr, m_pop, m_hit;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_st = S_IDLE; m_t = 0; m_ph = 0; m_ovf = 0; m_alarm = 0;
         m_q.delete();
      end else begin
         m_tick = (m_st == S_RUN) && (m_ph == DIV - 1);
         m_lap  = bus.i_lap && (m_st == S_RUN);
         m_clr  = bus.i_clear && (m_st != S_RUN);
         m_hit  = 0;
`ifdef COUNTDOWN_STOP_EN
         m_hit  = m_tick && bus.i_mode && (m_t <= 1);
`endif
         if (m_clr) begin
            m_q.delete();
            m_ovf = 0;
            m_t = 0; m_ph = 0; m_st = S_IDLE;
         end else begin
            m_pop = bus.i_lap_pop && (m_q.size() > 0);
            if (m_pop) void'(m_q.pop_front());
            if (m_lap) begin
               if (m_q.size() < LAP_DEPTH) m_q.push_back(pack(m_t));
               else m_ovf = 1;
            end
            if (m_hit) m_t = 0;
            else if (m_tick) m_t = bus.i_mode ? (m_t + MOD - 1) % MOD : (m_t + 1) % MOD;
            if (m_st == S_RUN) m_ph = m_tick ? 0 : m_ph + 1;
            if (m_hit) m_st = S_DONE;
            else if (bus.i_run_stop && m_st != S_DONE) m_st = (m_st == S_RUN) ? S_STOP : S_RUN;
         end
         m_alarm = m_hit;
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      check("model_time", bus.o_time, pack(m_t));
      check("model_lap_count", 32'(bus.o_lap_count), 32'(m_q.size()));
      check("model_lap_valid", 32'(bus.o_lap_valid), 32'(m_q.size() != 0));
      check("model_lap_data", bus.o_lap_data, (m_q.size() != 0) ? m_q[0] : 32'd0);
      check("model_lap_ovf", 32'(bus.o_lap_ovf), 32'(m_ovf));
      check("model_running", 32'(bus.o_running), 32'(m_st == S_RUN));
      check("model_alarm", 32'(bus.o_alarm), 32'(m_alarm));
   end

   // Each pulse is raised at a falling edge and dropped at the next one.
   task automatic pulse_run();   bus.i_run_stop = 1'b1; @(negedge clk); bus.i_run_stop = 1'b0; endtask
   task automatic pulse_clear(); bus.i_clear    = 1'b1; @(negedge clk); bus.i_clear    = 1'b0; endtask
   task automatic pulse_lap();   bus.i_lap      = 1'b1; @(negedge clk); bus.i_lap      = 1'b0; endtask
   task automatic pulse_pop();   bus.i_lap_pop  = 1'b1; @(negedge clk); bus.i_lap_pop  = 1'b0; endtask
   task automatic wait_clk(input int n); repeat (n) @(negedge clk); endtask

   initial begin
      bus.i_run_stop = 1'b0; bus.i_clear = 1'b0; bus.i_mode = 1'b0;
      bus.i_lap = 1'b0; bus.i_lap_pop = 1'b0;
      #1 rst = 1'b1;
      wait_clk(2);
      rst = 1'b0;
      check("reset_time", bus.o_time, 32'h0);
      check("reset_running", 32'(bus.o_running), 32'd0);

      // One second of up counting.
      pulse_run();
      wait_clk(1000);
      check("one_second", bus.o_time, 32'h0000_0100);
      check("one_second_running", 32'(bus.o_running), 32'd1);

      // Stop/resume keeps prescaler phase: 25 ticks, pause, 75 ticks.
      pulse_run();
      pulse_clear();
      check("clear_after_stop", bus.o_time, 32'h0);
      pulse_run();
      wait_clk(250);
      pulse_run();
      wait_clk(100);
      check("paused_value", bus.o_time, 32'h0000_0019);
      pulse_run();
      wait_clk(748);
      check("resume_pre_last", bus.o_time, 32'h0000_0063);
      wait_clk(1);
      check("resume_total", bus.o_time, 32'h0000_0100);

`ifndef COUNTDOWN_STOP_EN
      // Down wrap from zero, up wrap from the maximum, mode change mid-interval.
      pulse_run();
      pulse_clear();
      bus.i_mode = 1'b1;
      pulse_run();
      wait_clk(10);
      check("down_wrap", bus.o_time, 32'h173B_3B63);
      bus.i_mode = 1'b0;
      wait_clk(10);
      check("up_wrap", bus.o_time, 32'h0000_0000);
      wait_clk(5);
      bus.i_mode = 1'b1;
      wait_clk(5);
      check("down_wrap_again", bus.o_time, 32'h173B_3B63);
      wait_clk(10);
      check("down_borrow", bus.o_time, 32'h173B_3B62);
`endif

      // Laps: overflow, drain, extra pop, clear rules.
      pulse_run();
      pulse_clear();
      bus.i_mode = 1'b0;
      pulse_run();
      wait_clk(25);
      pulse_lap();
      check("first_lap_data", bus.o_lap_data, 32'h0000_0002);
      check("first_lap_valid", 32'(bus.o_lap_valid), 32'd1);
      for (int i = 0; i < 4; i++) begin
         wait_clk(30);
         pulse_lap();
      end
      check("full_count", 32'(bus.o_lap_count), 32'd4);
      check("full_ovf", 32'(bus.o_lap_ovf), 32'd1);
      check("full_head", bus.o_lap_data, 32'h0000_0002);
      for (int i = 0; i < 4; i++) pulse_pop();
      check("drained_valid", 32'(bus.o_lap_valid), 32'd0);
      pulse_pop();
      check("extra_pop_count", 32'(bus.o_lap_count), 32'd0);
      pulse_clear();
      check("clear_in_run_running", 32'(bus.o_running), 32'd1);
      check("clear_in_run_ovf", 32'(bus.o_lap_ovf), 32'd1);
      pulse_run();
      pulse_clear();
      check("clear_stop_time", bus.o_time, 32'h0);
      check("clear_stop_ovf", 32'(bus.o_lap_ovf), 32'd0);
      check("clear_stop_running", 32'(bus.o_running), 32'd0);
      bus.i_clear = 1'b1;
      pulse_run();
      bus.i_clear = 1'b0;
      check("clear_beats_run", 32'(bus.o_running), 32'd0);
      pulse_run();
      for (int i = 0; i < 4; i++) begin
         wait_clk(7);
         pulse_lap();
      end
      bus.i_lap_pop = 1'b1;
      pulse_lap();
      bus.i_lap_pop = 1'b0;
      check("lap_pop_full_count", 32'(bus.o_lap_count), 32'd4);
      check("lap_pop_full_ovf", 32'(bus.o_lap_ovf), 32'd0);
      pulse_run();
      pulse_pop();
      check("pop_in_stop", 32'(bus.o_lap_count), 32'd3);

`ifdef COUNTDOWN_STOP_EN
      // Countdown from 0:0:0:2 stops at zero with a single alarm pulse.
      pulse_clear();
      bus.i_mode = 1'b0;
      pulse_run();
      wait_clk(20);
      check("cd_preload", bus.o_time, 32'h0000_0002);
      bus.i_mode = 1'b1;
      wait_clk(20);
      check("cd_zero", bus.o_time, 32'h0);
      check("cd_alarm", 32'(bus.o_alarm), 32'd1);
      wait_clk(1);
      check("cd_alarm_drop", 32'(bus.o_alarm), 32'd0);
      wait_clk(500);
      pulse_run();
      check("cd_done_time", bus.o_time, 32'h0);
      check("cd_done_running", 32'(bus.o_running), 32'd0);
      pulse_clear();
      pulse_run();
      check("cd_clear_to_idle", 32'(bus.o_running), 32'd1);
`endif

      wait_clk(20);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/lap_timer_core.md
# lap_timer_core

Parametrised successor of the stopwatch datapath: a run/stop/clear time counter (hour:min:sec:centisecond) with an internal prescaler, an up/down count mode, and a lap-capture FIFO that software or the display path drains through a valid/ready-style pop. It sits between the debounced-button control unit and the display mux. It replaces the separate per-field counter instances with one chained counter and adds lap buffering.

## Interface
- CLK_HZ, 100_000_000, input clock frequency
- TICK_HZ, 100, centisecond tick rate; prescaler terminal count = CLK_HZ/TICK_HZ - 1
- HOUR_MAX, 24, hour field modulus (legal 1..99)
- LAP_DEPTH, 4, lap FIFO entries (power of two, 2..16)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_run_stop  in  1  one-cycle pulse, toggles RUN/STOP
- i_clear  in  1  one-cycle pulse, clear time, FIFO and flags
- i_mode  in  1  0 = count up, 1 = count down (level)
- i_lap  in  1  one-cycle pulse, capture current time into FIFO
- i_lap_pop  in  1  one-cycle pulse, discard FIFO head
- o_time  out  32  {hour, min, sec, csec}, each byte zero-extended
- o_lap_data  out  32  FIFO head, same packing as o_time
- o_lap_valid  out  1  FIFO non-empty
- o_lap_count  out  $clog2(LAP_DEPTH)+1  FIFO occupancy
- o_lap_ovf  out  1  sticky: a lap was dropped while full
- o_running  out  1  state == RUN
- o_alarm  out  1  one-cycle pulse on countdown reaching zero (macro only)

## Operation
- States: IDLE (reset), RUN, STOP; DONE exists only with the macro.
- IDLE --i_run_stop--> RUN; RUN --i_run_stop--> STOP; STOP --i_run_stop--> RUN.
- i_clear honoured in IDLE/STOP/DONE: next state IDLE, time = 0, prescaler = 0, FIFO emptied, o_lap_ovf = 0. Ignored in RUN.
- i_run_stop and i_clear in the same cycle: i_clear wins if honoured, otherwise i_run_stop acts.
- Prescaler advances only in RUN; holds its value in STOP (resume keeps phase); terminal count emits internal tick and wraps to 0.
- On tick, up mode: csec 0..99, carry to sec 0..59, min 0..59, hour 0..HOUR_MAX-1; full wrap HOUR_MAX-1:59:59:99 -> 00:00:00:00.
- On tick, down mode: borrow chain mirrors up mode; 00:00:00:00 -> HOUR_MAX-1:59:59:99 (no macro).
- i_mode changes take effect on the next tick; no counter disturbance.
- i_lap honoured only in RUN; captures the o_time value present in that cycle (pre-tick value if a tick coincides).
- Lap while full: dropped, o_lap_ovf set. Lap + pop same cycle while full: both performed, no overflow. Pop while empty: ignored.

## Timing
- Reset: o_time = 0, o_lap_data = 0, o_lap_valid = 0, o_lap_count = 0, o_lap_ovf = 0, o_running = 0, o_alarm = 0, state IDLE.
- o_time registered; updates the cycle after the internal tick.
- First tick after IDLE->RUN occurs CLK_HZ/TICK_HZ cycles after the run pulse edge.
- FIFO is first-word-fall-through: o_lap_data/o_lap_valid valid one cycle after the capturing i_lap; pop changes head the next cycle.
- o_running asserts the cycle after the accepting i_run_stop.

## Configuration
- COUNTDOWN_STOP_EN defined: in down mode, a tick that produces 00:00:00:00 moves to DONE, pulses o_alarm for one cycle, freezes time and prescaler; i_run_stop ignored in DONE; only i_clear exits (to IDLE). Ticks at 00:00:00:00 never wrap.
- Undefined: no DONE state, down mode wraps as in Operation, o_alarm tied 0.

## Test plan
Bench uses CLK_HZ=1000, TICK_HZ=100 (10 clocks/tick), HOUR_MAX=24, LAP_DEPTH=4.
- Reset, run pulse, wait 1000 clocks -> o_time = 0x00000100 (0:0:1:0), o_running = 1.
- Run, stop after 25 ticks, wait 100 clocks, run again, 75 ticks -> o_time = 0x00000100; no lost/extra tick across stop.
- Preload via up-run to 23:59:59:99, one tick -> o_time = 0x00000000; down mode from 0 one tick -> 0x173B3B63 (macro undefined).
- Five laps in RUN without pop -> o_lap_count = 4, o_lap_ovf = 1, head = first capture; pop 4 -> o_lap_valid = 0; extra pop ignored.
- Clear during RUN -> ignored; clear in STOP -> o_time = 0, count = 0, ovf = 0, state IDLE.
- COUNTDOWN_STOP_EN: down mode from 0:0:0:2, run -> after 2 ticks o_time = 0, o_alarm one pulse, further 50 ticks and run pulse -> unchanged; clear -> IDLE.
